// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: table index modes,
// counter reset value and the lookup/update index hash.
// Pure definitions, no state.
package bp_pkg;

    typedef enum logic {
        BP_CONCAT = 1'b0,
        BP_GSHARE = 1'b1
    } bp_mode_e;

    // Weakly not-taken: MSB clear, every lower bit set.
    function automatic int bp_ctr_init(input int ctr_w);
        return (1 << (ctr_w - 1)) - 1;
    endfunction

    // Lookup and update must hash identically so both reach the same entry.
    function automatic logic [31:0] bp_hash(
        input bp_mode_e    mode,
        input int          idx_w,
        input logic [31:0] idx,
        input logic [31:0] hist
    );
        if (mode == BP_CONCAT)
            return (hist << idx_w) | idx;
        return idx ^ hist;
    endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Saturating up/down counter next-state logic for one predictor entry.
// Latency: combinational.
// Backpressure: none.
module bp_sat_ctr #(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] ctr_q,
    input  logic             taken,
    output logic [CTR_W-1:0] ctr_d
);

    always_comb begin
        ctr_d = ctr_q;
        if (taken) begin
            if (ctr_q != '1)
                ctr_d = ctr_q + CTR_W'(1);
        end else begin
            if (ctr_q != '0)
                ctr_d = ctr_q - CTR_W'(1);
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// Global-history branch predictor with saturating counters and update stats.
// Latency: 1 cycle from accepted request to pred_out_valid; updates land next edge.
// Backpressure: pred_ready drops combinationally in any cycle carrying a mispredict.
module gshare_predictor
    import bp_pkg::*;
#(
    parameter int       IDX_W  = 4,
    parameter int       HIST_W = 3,
    parameter int       CTR_W  = 2,
    parameter bp_mode_e MODE   = BP_GSHARE,
    parameter int       STAT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pred_valid,
    output logic              pred_ready,
    input  logic [IDX_W-1:0]  pred_index,
    output logic              pred_out_valid,
    output logic              prediction,
    output logic [HIST_W-1:0] pred_hist,
    input  logic              upd_valid,
    input  logic [IDX_W-1:0]  upd_index,
    input  logic [HIST_W-1:0] upd_hist,
    input  logic              upd_taken,
    input  logic              upd_pred,
    output logic              success,
    output logic [STAT_W-1:0] stat_total,
    output logic [STAT_W-1:0] stat_miss
);

    localparam int               TBL_W   = (MODE == BP_CONCAT) ? IDX_W + HIST_W : IDX_W;
    localparam int               TBL_N   = 1 << TBL_W;
    localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(bp_ctr_init(CTR_W));

    typedef struct packed {
        logic              vld;
        logic              taken;
        logic [HIST_W-1:0] hist;
    } rsp_t;

    logic [CTR_W-1:0]  tbl_q [TBL_N];
    logic [HIST_W-1:0] ghr_q;
    rsp_t              rsp_q;
    logic              success_q;
    logic [STAT_W-1:0] stat_total_q;
    logic [STAT_W-1:0] stat_miss_q;

    logic [TBL_W-1:0]  lk_idx;
    logic [TBL_W-1:0]  upd_idx;
    logic              lk_taken;
    logic              lk_acc;
    logic              mispredict;
    logic [CTR_W-1:0]  ctr_nxt;
    logic [HIST_W-1:0] ghr_shift;
    logic [HIST_W-1:0] ghr_fix;

    assign mispredict = upd_valid & (upd_taken != upd_pred);
    assign pred_ready = ~mispredict;
    assign lk_acc     = pred_valid & pred_ready;

    assign lk_idx   = TBL_W'(bp_hash(MODE, IDX_W, 32'(pred_index), 32'(ghr_q)));
    // Resolved branches carry their own history snapshot; the live GHR has moved on.
    assign upd_idx  = TBL_W'(bp_hash(MODE, IDX_W, 32'(upd_index), 32'(upd_hist)));
    assign lk_taken = tbl_q[lk_idx][CTR_W-1];

    if (HIST_W > 1) begin : g_hist_multi
        assign ghr_shift = {ghr_q[HIST_W-2:0], lk_taken};
        assign ghr_fix   = {upd_hist[HIST_W-2:0], upd_taken};
    end else begin : g_hist_single
        assign ghr_shift = lk_taken;
        assign ghr_fix   = upd_taken;
    end

    bp_sat_ctr #(
        .CTR_W (CTR_W)
    ) u_sat_ctr (
        .ctr_q (tbl_q[upd_idx]),
        .taken (upd_taken),
        .ctr_d (ctr_nxt)
    );

    // Lookup reads tbl_q combinationally before this edge's write, giving read-before-write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TBL_N; i++)
                tbl_q[i] <= CTR_RST;
        end else if (upd_valid) begin
            tbl_q[upd_idx] <= ctr_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr_q <= '0;
        end else if (mispredict) begin
            ghr_q <= ghr_fix;
        end else if (lk_acc) begin
            ghr_q <= ghr_shift;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_q     <= '0;
            success_q <= 1'b0;
        end else begin
            rsp_q.vld <= lk_acc;
            if (lk_acc) begin
                rsp_q.taken <= lk_taken;
                rsp_q.hist  <= ghr_q;
            end
            success_q <= upd_valid & ~mispredict;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_total_q <= '0;
            stat_miss_q  <= '0;
        end else begin
            if (upd_valid && stat_total_q != '1)
                stat_total_q <= stat_total_q + STAT_W'(1);
            if (mispredict && stat_miss_q != '1)
                stat_miss_q <= stat_miss_q + STAT_W'(1);
        end
    end

    assign pred_out_valid = rsp_q.vld;
    assign prediction     = rsp_q.taken;
    assign pred_hist      = rsp_q.hist;
    assign success        = success_q;
    assign stat_total     = stat_total_q;
    assign stat_miss      = stat_miss_q;

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed-vector bench for gshare_predictor (IDX_W=4, HIST_W=3, CTR_W=2, gshare mode).
// Narrow stat counters so saturation is reachable in a few cycles.
module tb_gshare_predictor;
    import bp_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pred_valid;
    logic       pred_ready;
    logic [3:0] pred_index;
    logic       pred_out_valid;
    logic       prediction;
    logic [2:0] pred_hist;
    logic       upd_valid;
    logic [3:0] upd_index;
    logic [2:0] upd_hist;
    logic       upd_taken;
    logic       upd_pred;
    logic       success;
    logic [3:0] stat_total;
    logic [3:0] stat_miss;

    int n_vec  = 0;
    int n_miss = 0;

    gshare_predictor #(
        .IDX_W  (4),
        .HIST_W (3),
        .CTR_W  (2),
        .MODE   (BP_GSHARE),
        .STAT_W (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pred_valid     (pred_valid),
        .pred_ready     (pred_ready),
        .pred_index     (pred_index),
        .pred_out_valid (pred_out_valid),
        .prediction     (prediction),
        .pred_hist      (pred_hist),
        .upd_valid      (upd_valid),
        .upd_index      (upd_index),
        .upd_hist       (upd_hist),
        .upd_taken      (upd_taken),
        .upd_pred       (upd_pred),
        .success        (success),
        .stat_total     (stat_total),
        .stat_miss      (stat_miss)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pred_valid = 1'b0;
        pred_index = '0;
        upd_valid  = 1'b0;
        upd_index  = '0;
        upd_hist   = '0;
        upd_taken  = 1'b0;
        upd_pred   = 1'b0;
    endtask

    task automatic predict(input logic [3:0] idx);
        pred_valid = 1'b1;
        pred_index = idx;
    endtask

    task automatic update(input logic [3:0] idx, input logic [2:0] hist,
                          input logic taken, input logic pred);
        upd_valid = 1'b1;
        upd_index = idx;
        upd_hist  = hist;
        upd_taken = taken;
        upd_pred  = pred;
    endtask

    initial begin
        idle();
        step();
        chk("rst_vld",   32'(pred_out_valid), 0);
        chk("rst_pred",  32'(prediction), 0);
        chk("rst_hist",  32'(pred_hist), 0);
        chk("rst_succ",  32'(success), 0);
        chk("rst_total", 32'(stat_total), 0);
        chk("rst_miss",  32'(stat_miss), 0);
        reset = 1'b1;
        step();

        // First lookup: entry 5 weakly not-taken, GHR 000 shifts in 0.
        predict(4'd5);
        #1 chk("rdy_idle", 32'(pred_ready), 1);
        step(); idle();
        chk("p1_vld",  32'(pred_out_valid), 1);
        chk("p1_pred", 32'(prediction), 0);
        chk("p1_hist", 32'(pred_hist), 0);
        step();
        chk("p1_pulse", 32'(pred_out_valid), 0);

        // Two mispredicted taken updates: entry 5 goes 01->10->11, GHR loads 001.
        for (int i = 0; i < 2; i++) begin
            update(4'd5, 3'b000, 1'b1, 1'b0);
            #1 chk("rdy_misp", 32'(pred_ready), 0);
            step(); idle();
            chk("misp_succ", 32'(success), 0);
        end
        chk("s1_miss",  32'(stat_miss), 2);
        chk("s1_total", 32'(stat_total), 2);

        // GHR is 001, so index 4 hashes onto entry 5.
        predict(4'd4);
        step(); idle();
        chk("p2_pred", 32'(prediction), 1);
        chk("p2_hist", 32'(pred_hist), 3'b001);

        // Entry 5 stays saturated at 11 under correct taken updates, then drops to 10.
        for (int i = 0; i < 3; i++) begin
            update(4'd5, 3'b000, 1'b1, 1'b1);
            step(); idle();
            chk("sat_succ", 32'(success), 1);
        end
        update(4'd5, 3'b000, 1'b0, 1'b0);
        step(); idle();
        chk("dec_succ", 32'(success), 1);

        // GHR is 011 now; index 6 reaches entry 5.
        predict(4'd6);
        step(); idle();
        chk("p3_pred",  32'(prediction), 1);
        chk("p3_hist",  32'(pred_hist), 3'b011);
        chk("s2_total", 32'(stat_total), 6);
        chk("s2_miss",  32'(stat_miss), 2);

        // Mispredict with a concurrent request: request refused, GHR loads 101.
        predict(4'd1);
        update(4'd2, 3'b010, 1'b1, 1'b0);
        #1 chk("rdy_misp2", 32'(pred_ready), 0);
        step(); idle();
        chk("p4_vld",   32'(pred_out_valid), 0);
        chk("m2_succ",  32'(success), 0);
        chk("s3_miss",  32'(stat_miss), 3);
        chk("s3_total", 32'(stat_total), 7);

        // Same-cycle lookup and correct not-taken update on entry 5 (holds 10).
        predict(4'd0);
        update(4'd5, 3'b000, 1'b0, 1'b0);
        #1 chk("rdy_rbw", 32'(pred_ready), 1);
        step(); idle();
        chk("p5_vld",  32'(pred_out_valid), 1);
        chk("p5_pred", 32'(prediction), 1);
        chk("p5_hist", 32'(pred_hist), 3'b101);
        chk("p5_succ", 32'(success), 1);

        // GHR 011 after the taken prediction; entry 5 now 01.
        predict(4'd6);
        step(); idle();
        chk("p6_pred", 32'(prediction), 0);
        chk("p6_hist", 32'(pred_hist), 3'b011);

        // Push entry 5 back to 10, then reset while a response is showing.
        update(4'd5, 3'b000, 1'b1, 1'b1);
        step(); idle();
        predict(4'd5);
        step(); idle();
        chk("p7_vld", 32'(pred_out_valid), 1);
        reset = 1'b0;
        #1;
        chk("ar_vld",   32'(pred_out_valid), 0);
        chk("ar_total", 32'(stat_total), 0);
        chk("ar_miss",  32'(stat_miss), 0);
        chk("ar_hist",  32'(pred_hist), 0);
        chk("ar_succ",  32'(success), 0);
        step();
        reset = 1'b1;
        step();
        chk("ar_quiet1", 32'(pred_out_valid), 0);
        step();
        chk("ar_quiet2", 32'(pred_out_valid), 0);

        predict(4'd5);
        step(); idle();
        chk("p8_vld",  32'(pred_out_valid), 1);
        chk("p8_pred", 32'(prediction), 0);
        chk("p8_hist", 32'(pred_hist), 0);

        // Floor saturation on entry 3: 01->00->00, then 01->10.
        for (int i = 0; i < 2; i++) begin
            update(4'd3, 3'b000, 1'b0, 1'b0);
            step(); idle();
        end
        predict(4'd3);
        step(); idle();
        chk("p9_pred", 32'(prediction), 0);
        chk("p9_hist", 32'(pred_hist), 0);
        for (int i = 0; i < 2; i++) begin
            update(4'd3, 3'b000, 1'b1, 1'b1);
            step(); idle();
        end
        predict(4'd3);
        step(); idle();
        chk("p10_pred", 32'(prediction), 1);
        chk("p10_hist", 32'(pred_hist), 0);
        chk("s4_total", 32'(stat_total), 4);
        chk("s4_miss",  32'(stat_miss), 0);

        // Stats stick at all-ones.
        for (int i = 0; i < 20; i++) begin
            update(4'd1, 3'b000, 1'b1, 1'b0);
            step(); idle();
        end
        chk("sat_total", 32'(stat_total), 4'hF);
        chk("sat_miss",  32'(stat_miss), 4'hF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
